// File: rtl/mark_search_if.sv
// mark_search_if: handshake and data bundle between the mark assembly and one mark_search_unit
// Signals driven by the master (the assembly):
//   take_control, enabled, start_value, limit, distances, marks_in
// Signals driven by the slave (the search cell):
//   ready, val, next_enabled, next_start_value, pd_hash, found, exhausted
// Both hashes are declared [MAXVALUE:1], so bit d stands for distance d.
interface mark_search_if #(
  parameter int NUM_MARKS = 8,
  parameter int VW = 8,
  parameter int MAXVALUE = 128,
  parameter int IW = 4
);
  logic                    take_control;
  logic [IW-1:0]           enabled;
  logic [VW-1:0]           start_value;
  logic [VW-1:0]           limit;
  logic [MAXVALUE:1]       distances;
  logic [NUM_MARKS*VW-1:0] marks_in;
  logic                    ready;
  logic [VW-1:0]           val;
  logic [IW-1:0]           next_enabled;
  logic [VW-1:0]           next_start_value;
  logic [MAXVALUE:1]       pd_hash;
  logic                    found;
  logic                    exhausted;
  modport master (
    output take_control, enabled, start_value, limit, distances, marks_in,
    input  ready, val, next_enabled, next_start_value, pd_hash, found, exhausted
  );
  modport slave (
    input  take_control, enabled, start_value, limit, distances, marks_in,
    output ready, val, next_enabled, next_start_value, pd_hash, found, exhausted
  );
endinterface

// File: rtl/mark_search_unit.sv
// mark_search_unit: one mark of the Golomb ruler search (advance, limit check, serial distance check)
// Ports: clock, reset (sync, active-high), bus (mark_search_if.slave):
//   in  take_control, enabled, start_value, limit, distances, marks_in
//   out ready, val, next_enabled, next_start_value, pd_hash, found, exhausted
// Optional build macro MIRROR_PRUNE_EN: LEVEL 1 rejects candidates with 2*val >= limit.
module mark_search_unit #(
  parameter int LEVEL = 1,
  parameter int NUM_MARKS = 8,
  parameter int VW = 8,
  parameter int MAXVALUE = 128,
  parameter int IW = 4
) (
  input logic          clock,
  input logic          reset,
  mark_search_if.slave bus
);
  localparam logic [IW-1:0] ME = IW'(LEVEL);
  localparam bit LEAF = LEVEL == NUM_MARKS - 1;
  typedef enum logic [2:0] {IDLE, ADVANCE, LIMITCHK, CHECK, DECIDE, BACKTRACK, DONE} state_t;
  state_t            state, st_n;
  logic [VW-1:0]     val, val_n, nsv, nsv_n, mk, d;
  logic [IW-1:0]     j, j_n, ne, ne_n;
  logic [MAXVALUE:1] pd, pd_n;
  logic              cy, cy_n, cl, cl_n, rdy, rdy_n, fnd, fnd_n, exh, exh_n;
  logic              bad, lim_fail, mir;
  assign mk = bus.marks_in[j*VW +: VW];
  assign d = val - mk;
  // distance 0, out of hash range, already used below, or repeated by this mark
  assign bad = d == '0 || int'(d) > MAXVALUE || bus.distances[d] || pd[d];
`ifdef MIRROR_PRUNE_EN
  // second mark past half the limit only revisits mirror images already searched
  assign mir = LEVEL == 1 && {val, 1'b0} >= {1'b0, bus.limit};
`else
  assign mir = 1'b0;
`endif
  // leaf may land exactly on the limit, inner marks must leave room above them
  assign lim_fail = cy || (LEAF ? val > bus.limit : val >= bus.limit) || mir;
  always_comb begin
    st_n = state;
    val_n = val;
    cy_n = cy;
    j_n = j;
    pd_n = pd;
    cl_n = cl;
    ne_n = ne;
    nsv_n = nsv;
    rdy_n = rdy;
    fnd_n = 1'b0;
    exh_n = 1'b0;
    if (state != IDLE && bus.enabled != ME) begin
      st_n = IDLE;
      rdy_n = 1'b1;
      pd_n = '0;
    end else begin
      case (state)
        IDLE: if (bus.take_control && bus.enabled == ME) begin
          st_n = ADVANCE;
          rdy_n = 1'b0;
        end
        ADVANCE: begin
          {cy_n, val_n} = val == '0 ? {1'b0, bus.start_value} : {1'b0, val} + 1'b1;
          pd_n = '0;
          j_n = '0;
          cl_n = 1'b0;
          st_n = LIMITCHK;
        end
        LIMITCHK: st_n = lim_fail ? BACKTRACK : LEVEL == 0 ? DECIDE : CHECK;
        CHECK: begin
          if (bad) begin
            cl_n = 1'b1;
            st_n = DECIDE;
          end else begin
            pd_n[d] = 1'b1;
            j_n = j + 1'b1;
            st_n = int'(j) == LEVEL - 1 ? DECIDE : CHECK;
          end
        end
        DECIDE: begin
          if (cl) begin
            pd_n = '0;
            ne_n = ME;
          end else if (LEAF) begin
            ne_n = ME;
            fnd_n = 1'b1;
          end else begin
            ne_n = IW'(LEVEL + 1);
            nsv_n = val + 1'b1;
          end
          st_n = DONE;
        end
        BACKTRACK: begin
          val_n = '0;
          pd_n = '0;
          nsv_n = '0;
          ne_n = LEVEL == 0 ? '0 : IW'(LEVEL - 1);
          exh_n = LEVEL == 0;
          st_n = DONE;
        end
        DONE: begin
          rdy_n = 1'b1;
          st_n = IDLE;
        end
        default: st_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      val <= '0;
      cy <= 1'b0;
      j <= '0;
      pd <= '0;
      cl <= 1'b0;
      ne <= ME;
      nsv <= '0;
      rdy <= 1'b1;
      fnd <= 1'b0;
      exh <= 1'b0;
    end else begin
      state <= st_n;
      val <= val_n;
      cy <= cy_n;
      j <= j_n;
      pd <= pd_n;
      cl <= cl_n;
      ne <= ne_n;
      nsv <= nsv_n;
      rdy <= rdy_n;
      fnd <= fnd_n;
      exh <= exh_n;
    end
  end
  assign bus.ready = rdy;
  assign bus.val = val;
  assign bus.next_enabled = ne;
  assign bus.next_start_value = nsv;
  assign bus.pd_hash = pd;
  assign bus.found = fnd;
  assign bus.exhausted = exh;
endmodule

// File: tb/tb_mark_search_unit.sv
// tb_mark_search_unit: directed checks of mark_search_unit at ranks 0..3
module tb_mark_search_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n = 0;
  int errs = 0;
  int fcnt = 0;
  int xcnt = 0;
  always #5 clock = ~clock;
  mark_search_if #(.NUM_MARKS(8)) i0 ();
  mark_search_if #(.NUM_MARKS(8)) i1 ();
  mark_search_if #(.NUM_MARKS(8)) i2 ();
  mark_search_if #(.NUM_MARKS(4)) i3 ();
  mark_search_unit #(.LEVEL(0), .NUM_MARKS(8)) u0 (.clock(clock), .reset(reset), .bus(i0));
  mark_search_unit #(.LEVEL(1), .NUM_MARKS(8)) u1 (.clock(clock), .reset(reset), .bus(i1));
  mark_search_unit #(.LEVEL(2), .NUM_MARKS(8)) u2 (.clock(clock), .reset(reset), .bus(i2));
  mark_search_unit #(.LEVEL(3), .NUM_MARKS(4)) u3 (.clock(clock), .reset(reset), .bus(i3));
  always @(negedge clock) begin
    fcnt <= fcnt + int'(i0.found === 1'b1) + int'(i1.found === 1'b1) + int'(i2.found === 1'b1) + int'(i3.found === 1'b1);
    xcnt <= xcnt + int'(i0.exhausted === 1'b1) + int'(i1.exhausted === 1'b1) + int'(i2.exhausted === 1'b1) + int'(i3.exhausted === 1'b1);
  end
  function automatic logic rdy(input int sel);
    case (sel)
      0: return i0.ready;
      1: return i1.ready;
      2: return i2.ready;
      default: return i3.ready;
    endcase
  endfunction
  task automatic set_take(input int sel, input logic v);
    case (sel)
      0: i0.take_control = v;
      1: i1.take_control = v;
      2: i2.take_control = v;
      default: i3.take_control = v;
    endcase
  endtask
  task automatic step(input int sel, output int cyc);
    @(negedge clock);
    set_take(sel, 1'b1);
    @(negedge clock);
    set_take(sel, 1'b0);
    cyc = 0;
    while (rdy(sel) !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
  endtask
  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic setup_l2(input logic [7:0] sv);
    i2.marks_in = '0;
    i2.marks_in[15:8] = 8'd1;
    i2.distances = '0;
    i2.distances[1] = 1'b1;
    i2.start_value = sv;
    i2.limit = 8'd10;
    i2.enabled = 4'd2;
  endtask
  task automatic test_reset;
    int f0, x0;
    do_reset;
    f0 = fcnt;
    x0 = xcnt;
    n++; if (i2.val !== 8'd0) begin errs++; $display("FAIL reset_val got %0d want 0", i2.val); end
    n++; if (i2.next_enabled !== 4'd2) begin errs++; $display("FAIL reset_next_enabled got %0d want 2", i2.next_enabled); end
    n++; if (i2.pd_hash !== '0) begin errs++; $display("FAIL reset_pd_hash got %0h want 0", i2.pd_hash); end
    n++; if (i2.ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %0b want 1", i2.ready); end
    n++; if (i2.next_start_value !== 8'd0) begin errs++; $display("FAIL reset_next_start got %0d want 0", i2.next_start_value); end
    n++; if (i0.next_enabled !== 4'd0 || i3.next_enabled !== 4'd3) begin errs++; $display("FAIL reset_ne_others got %0d/%0d want 0/3", i0.next_enabled, i3.next_enabled); end
    repeat (5) @(negedge clock);
    n++; if (fcnt != f0 || xcnt != x0) begin errs++; $display("FAIL reset_pulses got %0d/%0d want 0/0", fcnt - f0, xcnt - x0); end
  endtask
  task automatic test_good;
    int cyc;
    logic [128:1] e;
    do_reset;
    setup_l2(8'd3);
    step(2, cyc);
    e = '0;
    e[2] = 1'b1;
    e[3] = 1'b1;
    n++; if (cyc != 6) begin errs++; $display("FAIL good_latency got %0d want 6", cyc); end
    n++; if (i2.val !== 8'd3) begin errs++; $display("FAIL good_val got %0d want 3", i2.val); end
    n++; if (i2.pd_hash !== e) begin errs++; $display("FAIL good_pd_hash got %0h want %0h", i2.pd_hash, e); end
    n++; if (i2.next_enabled !== 4'd3) begin errs++; $display("FAIL good_next_enabled got %0d want 3", i2.next_enabled); end
    n++; if (i2.next_start_value !== 8'd4) begin errs++; $display("FAIL good_next_start got %0d want 4", i2.next_start_value); end
  endtask
  task automatic test_clash;
    int cyc;
    do_reset;
    setup_l2(8'd2);
    step(2, cyc);
    n++; if (cyc != 6) begin errs++; $display("FAIL clash_latency got %0d want 6", cyc); end
    n++; if (i2.val !== 8'd2) begin errs++; $display("FAIL clash_val got %0d want 2", i2.val); end
    n++; if (i2.next_enabled !== 4'd2) begin errs++; $display("FAIL clash_next_enabled got %0d want 2", i2.next_enabled); end
    n++; if (i2.pd_hash !== '0) begin errs++; $display("FAIL clash_pd_hash got %0h want 0", i2.pd_hash); end
  endtask
  task automatic test_backtrack;
    int cyc;
    do_reset;
    setup_l2(8'd9);
    step(2, cyc);
    n++; if (cyc != 6 || i2.val !== 8'd9) begin errs++; $display("FAIL bt_setup got cyc %0d val %0d want 6/9", cyc, i2.val); end
    step(2, cyc);
    n++; if (cyc != 4) begin errs++; $display("FAIL bt_latency got %0d want 4", cyc); end
    n++; if (i2.val !== 8'd0) begin errs++; $display("FAIL bt_val got %0d want 0", i2.val); end
    n++; if (i2.next_enabled !== 4'd1) begin errs++; $display("FAIL bt_next_enabled got %0d want 1", i2.next_enabled); end
    n++; if (i2.pd_hash !== '0 || i2.next_start_value !== 8'd0) begin errs++; $display("FAIL bt_clear got %0h/%0d want 0/0", i2.pd_hash, i2.next_start_value); end
  endtask
  task automatic test_exhaust;
    int cyc, x0;
    do_reset;
    i0.marks_in = '0;
    i0.distances = '0;
    i0.start_value = 8'd9;
    i0.limit = 8'd10;
    i0.enabled = 4'd0;
    step(0, cyc);
    n++; if (cyc != 4) begin errs++; $display("FAIL l0_good_latency got %0d want 4", cyc); end
    n++; if (i0.val !== 8'd9 || i0.next_enabled !== 4'd1) begin errs++; $display("FAIL l0_good got val %0d ne %0d want 9/1", i0.val, i0.next_enabled); end
    n++; if (i0.next_start_value !== 8'd10) begin errs++; $display("FAIL l0_next_start got %0d want 10", i0.next_start_value); end
    x0 = xcnt;
    step(0, cyc);
    @(negedge clock);
    n++; if (cyc != 4) begin errs++; $display("FAIL l0_bt_latency got %0d want 4", cyc); end
    n++; if (i0.val !== 8'd0 || i0.next_enabled !== 4'd0) begin errs++; $display("FAIL l0_bt got val %0d ne %0d want 0/0", i0.val, i0.next_enabled); end
    n++; if (xcnt - x0 != 1) begin errs++; $display("FAIL l0_exhausted got %0d pulses want 1", xcnt - x0); end
  endtask
  task automatic test_leaf;
    int cyc, f0;
    logic [128:1] e;
    do_reset;
    i3.marks_in = '0;
    i3.marks_in[15:8] = 8'd1;
    i3.marks_in[23:16] = 8'd4;
    i3.distances = '0;
    i3.distances[1] = 1'b1;
    i3.distances[3] = 1'b1;
    i3.distances[4] = 1'b1;
    i3.start_value = 8'd6;
    i3.limit = 8'd6;
    i3.enabled = 4'd3;
    e = '0;
    e[2] = 1'b1;
    e[5] = 1'b1;
    e[6] = 1'b1;
    f0 = fcnt;
    step(3, cyc);
    repeat (2) @(negedge clock);
    n++; if (cyc != 7) begin errs++; $display("FAIL leaf_latency got %0d want 7", cyc); end
    n++; if (fcnt - f0 != 1) begin errs++; $display("FAIL leaf_found got %0d pulses want 1", fcnt - f0); end
    n++; if (i3.pd_hash !== e) begin errs++; $display("FAIL leaf_pd_hash got %0h want %0h", i3.pd_hash, e); end
    n++; if (i3.val !== 8'd6 || i3.next_enabled !== 4'd3) begin errs++; $display("FAIL leaf_state got val %0d ne %0d want 6/3", i3.val, i3.next_enabled); end
  endtask
  task automatic test_deactivate;
    int f0;
    do_reset;
    setup_l2(8'd3);
    f0 = fcnt;
    @(negedge clock);
    i2.take_control = 1'b1;
    @(negedge clock);
    i2.take_control = 1'b0;
    repeat (3) @(negedge clock);
    n++; if (i2.ready !== 1'b0 || i2.pd_hash[3] !== 1'b1) begin errs++; $display("FAIL deact_midcheck got ready %0b pd3 %0b want 0/1", i2.ready, i2.pd_hash[3]); end
    i2.enabled = 4'd0;
    @(negedge clock);
    n++; if (i2.ready !== 1'b1) begin errs++; $display("FAIL deact_ready got %0b want 1", i2.ready); end
    n++; if (i2.pd_hash !== '0) begin errs++; $display("FAIL deact_pd_hash got %0h want 0", i2.pd_hash); end
    n++; if (i2.val !== 8'd3) begin errs++; $display("FAIL deact_val got %0d want 3", i2.val); end
    repeat (4) @(negedge clock);
    n++; if (fcnt != f0 || i2.next_enabled !== 4'd2 || i2.ready !== 1'b1) begin errs++; $display("FAIL deact_quiet got found %0d ne %0d ready %0b want 0/2/1", fcnt - f0, i2.next_enabled, i2.ready); end
    i2.enabled = 4'd2;
  endtask
  task automatic test_mirror;
    int cyc;
    do_reset;
    i1.marks_in = '0;
    i1.distances = '0;
    i1.start_value = 8'd5;
    i1.limit = 8'd10;
    i1.enabled = 4'd1;
    step(1, cyc);
`ifdef MIRROR_PRUNE_EN
    n++; if (cyc != 4) begin errs++; $display("FAIL mirror_latency got %0d want 4", cyc); end
    n++; if (i1.val !== 8'd0 || i1.next_enabled !== 4'd0) begin errs++; $display("FAIL mirror_bt got val %0d ne %0d want 0/0", i1.val, i1.next_enabled); end
`else
    n++; if (cyc != 5) begin errs++; $display("FAIL mirror_latency got %0d want 5", cyc); end
    n++; if (i1.val !== 8'd5 || i1.next_enabled !== 4'd2) begin errs++; $display("FAIL mirror_good got val %0d ne %0d want 5/2", i1.val, i1.next_enabled); end
    n++; if (i1.next_start_value !== 8'd6) begin errs++; $display("FAIL mirror_next_start got %0d want 6", i1.next_start_value); end
`endif
  endtask
  initial begin
    i0.take_control = 1'b0; i1.take_control = 1'b0; i2.take_control = 1'b0; i3.take_control = 1'b0;
    i0.enabled = 4'd0; i1.enabled = 4'd1; i2.enabled = 4'd2; i3.enabled = 4'd3;
    i0.start_value = '0; i1.start_value = '0; i2.start_value = '0; i3.start_value = '0;
    i0.limit = '0; i1.limit = '0; i2.limit = '0; i3.limit = '0;
    i0.distances = '0; i1.distances = '0; i2.distances = '0; i3.distances = '0;
    i0.marks_in = '0; i1.marks_in = '0; i2.marks_in = '0; i3.marks_in = '0;
    test_reset;
    test_good;
    test_clash;
    test_backtrack;
    test_exhaust;
    test_leaf;
    test_deactivate;
    test_mirror;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule

// File: doc/mark_search_unit.md
# mark_search_unit

Parametrised search cell for one mark of the Golomb ruler search; supersedes the fixed-width mark counter. It advances its mark position, runs an integrated serial distance check against all lower-ranked marks, and publishes its new pairwise distances. It then hands control down (good), keeps it (clash) or passes it up (backtrack). One instance per mark rank sits in the mark assembly and is chained through `enabled`/`next_enabled`.

## Interface
- `LEVEL`, 1: rank of this mark on the ruler (0 = origin mark).
- `NUM_MARKS`, 8: total marks; `LEVEL == NUM_MARKS-1` is the leaf.
- `VW`, 8: position value width.
- `MAXVALUE`, 128: width of the distance hash; valid distances are 1..MAXVALUE.
- `IW`, 4: width of rank numbers (`enabled`, `next_enabled`).
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `take_control`  in  1  request to start one step; honoured only in IDLE with `enabled == LEVEL`.
- `enabled`  in  IW  rank currently owning the search.
- `start_value`  in  VW  first candidate when entering from reset position.
- `limit`  in  VW  current best length; positions must stay below it (leaf: at or below it).
- `distances`  in  MAXVALUE  bit d set = distance d already used by lower marks.
- `marks_in`  in  NUM_MARKS*VW  packed positions, mark j at bits [j*VW +: VW].
- `ready`  out  1  high when idle and able to accept `take_control`.
- `val`  out  VW  current position of this mark.
- `next_enabled`  out  IW  rank to own the search after this step.
- `next_start_value`  out  VW  first candidate for the next rank.
- `pd_hash`  out  MAXVALUE  distances contributed by this mark (valid after a good step).
- `found`  out  1  one-cycle pulse: leaf accepted a complete ruler.
- `exhausted`  out  1  one-cycle pulse: LEVEL 0 backtracked, search complete.

## Operation
- Reset values:
  - `val` = 0 (reset position).
  - `next_start_value` = 0.
  - `next_enabled` = LEVEL.
  - `pd_hash` = 0.
  - `ready` = 1; `found` = `exhausted` = 0.
  - state IDLE.
- States and transitions:
  - IDLE → ADVANCE on `take_control` && `enabled == LEVEL`; `ready` drops in the same edge.
  - ADVANCE:
    - If `val == 0`, then `val` := `start_value`; else `val` := `val+1`, computed VW+1 bits wide.
    - `pd_hash` := 0; j := 0; clash := 0.
  - LIMITCHK:
    - Backtrack when any of the following holds: carry out of the VW+1-bit add; `val >= limit` (non-leaf); `val > limit` (leaf).
    - Otherwise go to CHECK.
  - CHECK: one lower mark per cycle, j = 0..LEVEL-1.
    - d = `val - marks_in[j]`.
    - Clash if any of: d == 0; d > MAXVALUE; `distances[d]`; `pd_hash[d]` (duplicate within this mark).
    - No clash: set `pd_hash[d]`.
    - First clash aborts to DECIDE immediately.
  - DECIDE:
    - Clash: `pd_hash` := 0; `next_enabled` := LEVEL.
    - Good, non-leaf: `next_enabled` := LEVEL+1; `next_start_value` := `val+1`.
    - Good, leaf: `next_enabled` := LEVEL; pulse `found`; `pd_hash` retained.
    - Then go to DONE.
  - BACKTRACK:
    - `val` := 0; `pd_hash` := 0; `next_start_value` := 0.
    - `next_enabled` := LEVEL-1; at LEVEL 0, `next_enabled` stays 0 and `exhausted` pulses.
    - Then go to DONE.
  - DONE: `ready` := 1; → IDLE.
- Deactivation: `enabled != LEVEL` in any non-IDLE state forces IDLE next cycle.
  - `ready` := 1; `pd_hash` := 0; `val` held.
  - No `found` or `exhausted` pulse.
- Reset overrides everything, including a mid-CHECK step.
- LEVEL 0 skips CHECK (no lower marks); good whenever the limit check passes.

## Timing
- Good step latency: `take_control` edge → `ready` high = LEVEL+4 cycles (ADVANCE, LIMITCHK, LEVEL CHECK cycles, DECIDE, DONE).
- Clash at mark j: j+5 cycles. Backtrack: 4 cycles.
- `next_enabled`, `next_start_value` and `pd_hash` are stable from the cycle `ready` rises until the next `take_control` is accepted.
- Inputs `distances`, `marks_in` and `limit` must be held stable while `ready` is low.
- `take_control` while `ready` is low is ignored.

## Configuration
- `MIRROR_PRUNE_EN`, when defined, adds symmetry breaking for LEVEL 1 instances only: a candidate with `2*val >= limit` (VW+1-bit compare) is treated as a limit failure and backtracks. Each mirror pair is therefore explored once.
- Without the macro, LEVEL 1 uses the plain limit check. All other levels are unaffected either way.

## Test plan
- Reset with LEVEL=2: `val`=0, `next_enabled`=2, `pd_hash`=0, `ready`=1; no pulses for 5 cycles.
- LEVEL=2, marks {0,1}, `distances` bit1 set, `start_value`=3, `limit`=10, take_control:
  - Expected: `val`=3, `pd_hash` bits {2,3}, `next_enabled`=3, `next_start_value`=4, `ready` after 6 cycles.
- Same setup with `start_value`=2: d=1 clashes at j=1; `next_enabled`=2, `pd_hash`=0, `ready` after 6 cycles.
- LEVEL=2, `val`=9, `limit`=10, take_control: `val`→10 fails; `val`=0, `next_enabled`=1, `ready` after 4 cycles.
  - Repeat at LEVEL 0: `exhausted` pulses once.
- Leaf LEVEL=3, marks {0,1,4}, `distances` {1,3,4}, `start_value`=6, `limit`=6: `found` pulses once; `pd_hash` = {2,5,6}.
- Deactivation: change `enabled` during CHECK: state returns to IDLE, `ready`=1, `pd_hash`=0.
- With `MIRROR_PRUNE_EN` defined: LEVEL 1, `start_value`=5, `limit`=10 backtracks.
- Without `MIRROR_PRUNE_EN`: the same stimulus returns good.
